// File: rtl/global_package.sv
// Shared TCP definitions: connection events/states plus the active-open handshake
// state encoding and segment flag-bit positions.
package global_package;

    typedef enum logic [3:0] {
        EV_NONE, EV_ACTIVE_OPEN, EV_PASSIVE_OPEN, EV_CLOSE,
        EV_RCV_SYN, EV_RCV_ACK, EV_RCV_RST, EV_TIMEOUT
    } e_events;

    typedef enum logic [3:0] {
        S_CLOSED, S_LISTEN, S_SYN_SENT, S_SYN_RCVD, S_ESTABLISHED,
        S_FIN_WAIT_1, S_FIN_WAIT_2, S_CLOSE_WAIT, S_CLOSING, S_LAST_ACK, S_TIME_WAIT
    } e_states;

    typedef enum logic [2:0] {
        CLOSED      = 3'd0,
        SYN_SEND    = 3'd1,
        SYN_SENT    = 3'd2,
        ACK_SEND    = 3'd3,
        RST_SEND    = 3'd4,
        ESTABLISHED = 3'd5
    } e_init_states;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_ACK = 3;

    function automatic logic [3:0] flag_mask(input int bit_idx);
        logic [3:0] m;
        m = 4'b0000;
        m[bit_idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/tcp_rto_timer.sv
// SYN retransmission timer: counts while start is high, holds otherwise,
// and flags expiry on the cycle the count sits at RTO_CYCLES-1.
module tcp_rto_timer #(
    parameter int RTO_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = (RTO_CYCLES > 2) ? $clog2(RTO_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(RTO_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign expired   = start && w_at_last;

    // Saturates at LAST so a paused count resumes already expired, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_cnt <= '0;
        else if (clear)              r_cnt <= '0;
        else if (start && !w_at_last) r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/tcp_active_open.sv
// Client side of the TCP three-way handshake: sends SYN, retransmits on RTO,
// answers SYN|ACK with ACK, answers unacceptable ACKs with RST.
module tcp_active_open
    import global_package::*;
#(
    parameter logic [31:0] ISS         = 32'h0000_1000,
    parameter int          RTO_CYCLES  = 1000,
    parameter int          MAX_RETRIES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        open_req,
    input  logic        seg_rx_valid,
    input  logic [3:0]  seg_rx_flags,
    input  logic [31:0] seg_rx_seq,
    input  logic [31:0] seg_rx_ack,
    output logic        seg_tx_valid,
    input  logic        seg_tx_ready,
    output logic [3:0]  seg_tx_flags,
    output logic [31:0] seg_tx_seq,
    output logic [31:0] seg_tx_ack,
    output logic [2:0]  state,
    output logic        established,
    output logic        conn_refused,
    output logic        conn_timeout,
    output logic        conn_reset
);

    localparam int          RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [31:0] ISS_P1 = ISS + 32'd1;

    e_init_states  r_state, w_next;
    logic [31:0]   r_irs, r_rst_seq;
    logic [RW-1:0] r_retry;
    logic          r_refused, r_timeout, r_reset;

    logic w_irs_ld, w_rst_ld, w_retry_inc;
    logic w_refused, w_timeout, w_reset;
    logic w_tmr_start, w_tmr_clear, w_expired;
    logic w_ack_ok, w_ack_bad;

    tcp_rto_timer #(.RTO_CYCLES(RTO_CYCLES)) u_rto (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_tmr_start),
        .clear  (w_tmr_clear),
        .expired(w_expired)
    );

    assign w_ack_ok  = seg_rx_valid && seg_rx_flags[FLAG_ACK] && (seg_rx_ack == ISS_P1);
    assign w_ack_bad = seg_rx_valid && seg_rx_flags[FLAG_ACK] && (seg_rx_ack != ISS_P1)
                       && !seg_rx_flags[FLAG_RST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLOSED;
            r_irs     <= '0;
            r_rst_seq <= '0;
            r_retry   <= '0;
            r_refused <= 1'b0;
            r_timeout <= 1'b0;
            r_reset   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_refused <= w_refused;
            r_timeout <= w_timeout;
            r_reset   <= w_reset;
            if (w_irs_ld) r_irs     <= seg_rx_seq;
            if (w_rst_ld) r_rst_seq <= seg_rx_ack;
            if (r_state == CLOSED || w_next == CLOSED) r_retry <= '0;
            else if (w_retry_inc)                      r_retry <= r_retry + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_irs_ld    = 1'b0;
        w_rst_ld    = 1'b0;
        w_retry_inc = 1'b0;
        w_refused   = 1'b0;
        w_timeout   = 1'b0;
        w_reset     = 1'b0;
        w_tmr_start = 1'b0;
        w_tmr_clear = 1'b0;
        case (r_state)
            CLOSED: begin
                w_tmr_clear = 1'b1;
                if (open_req) w_next = SYN_SEND;
            end
            SYN_SEND: begin
                w_tmr_clear = 1'b1;
                if (seg_tx_ready) w_next = SYN_SENT;
            end
            SYN_SENT: begin
                w_tmr_start = 1'b1;
                // A segment that acts pre-empts a coincident RTO expiry.
                if (w_ack_ok && seg_rx_flags[FLAG_RST]) begin
                    w_refused = 1'b1;
                    w_next    = CLOSED;
                end else if (w_ack_ok && seg_rx_flags[FLAG_SYN]) begin
                    w_irs_ld = 1'b1;
                    w_next   = ACK_SEND;
                end else if (w_ack_bad) begin
                    w_rst_ld = 1'b1;
                    w_next   = RST_SEND;
                end else if (w_expired) begin
                    if (r_retry == RW'(MAX_RETRIES)) begin
                        w_timeout = 1'b1;
                        w_next    = CLOSED;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_next      = SYN_SEND;
                    end
                end
            end
            ACK_SEND: if (seg_tx_ready) w_next = ESTABLISHED;
            RST_SEND: if (seg_tx_ready) w_next = SYN_SENT;
            ESTABLISHED: begin
                if (seg_rx_valid && seg_rx_flags[FLAG_RST] && (seg_rx_seq == r_irs + 32'd1)) begin
                    w_reset = 1'b1;
                    w_next  = CLOSED;
                end
            end
            default: w_next = CLOSED;
        endcase
    end

    // Tx fields decode straight from state so reset clears them asynchronously.
    always_comb begin
        seg_tx_valid = 1'b0;
        seg_tx_flags = 4'b0000;
        seg_tx_seq   = '0;
        seg_tx_ack   = '0;
        case (r_state)
            SYN_SEND: begin
                seg_tx_valid = 1'b1;
                seg_tx_flags = flag_mask(FLAG_SYN);
                seg_tx_seq   = ISS;
            end
            ACK_SEND: begin
                seg_tx_valid = 1'b1;
                seg_tx_flags = flag_mask(FLAG_ACK);
                seg_tx_seq   = ISS_P1;
                seg_tx_ack   = r_irs + 32'd1;
            end
            RST_SEND: begin
                seg_tx_valid = 1'b1;
                seg_tx_flags = flag_mask(FLAG_RST);
                seg_tx_seq   = r_rst_seq;
            end
            default: ;
        endcase
    end

    assign state        = r_state;
    assign established  = (r_state == ESTABLISHED);
    assign conn_refused = r_refused;
    assign conn_timeout = r_timeout;
    assign conn_reset   = r_reset;

endmodule

// File: doc/tcp_active_open.md
TCP_ACTIVE_OPEN -- requirements
Module: tcp_active_open

Interface
REQ-001 SHALL have parameter ISS, default 32'h0000_1000, the initial send sequence number.
REQ-002 SHALL have parameter RTO_CYCLES, default 1000, the retransmission timeout in clock cycles.
REQ-003 SHALL have parameter MAX_RETRIES, default 3, the number of SYN retransmissions before giving up.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port open_req, input, 1, a single-cycle ACTIVE_OPEN event.
REQ-007 SHALL have port seg_rx_valid, input, 1, a single-cycle received-segment strobe, always accepted.
REQ-008 SHALL have ports seg_rx_flags, input, 4, and seg_rx_seq and seg_rx_ack, input, 32 each, the received segment fields.
REQ-009 SHALL have port seg_tx_valid, output, 1, and seg_tx_ready, input, 1, the transmit handshake.
REQ-010 SHALL have ports seg_tx_flags, output, 4, and seg_tx_seq and seg_tx_ack, output, 32 each, the transmitted segment fields.
REQ-011 SHALL have port state, output, 3, the current e_init_states value.
REQ-012 SHALL have ports established, output, 1, a level; conn_refused, output, 1, a pulse; conn_timeout, output, 1, a pulse; conn_reset, output, 1, a pulse.

Function
REQ-013 Flag bits SHALL be: bit0 FIN, bit1 SYN, bit2 RST, bit3 ACK.
REQ-014 States SHALL be CLOSED, SYN_SEND, SYN_SENT, ACK_SEND, RST_SEND and ESTABLISHED.
REQ-015 CLOSED + open_req SHALL go to SYN_SEND next cycle; open_req in any other state SHALL be ignored.
REQ-016 SYN_SEND SHALL drive seg_tx_valid=1, flags=SYN, seq=ISS, ack=0, and go to SYN_SENT on the valid&&ready cycle.
REQ-017 In every *_SEND state, seg_tx_valid and all tx fields SHALL stay stable until ready; seg_tx_valid SHALL be 0 in all other states.
REQ-018 Segments arriving in CLOSED or any *_SEND state SHALL be ignored.
REQ-019 In SYN_SENT, the RTO counter SHALL start at 0 on entry and count every cycle.
REQ-020 When the RTO count reaches RTO_CYCLES-1 with retry_cnt<MAX_RETRIES, the block SHALL increment retry_cnt and go to SYN_SEND.
REQ-021 When the RTO count reaches RTO_CYCLES-1 with retry_cnt==MAX_RETRIES, the block SHALL pulse conn_timeout for 1 cycle and go to CLOSED.
REQ-022 SYN_SENT SHALL treat an rx segment with ACK set and ack==ISS+1 (mod 2^32) as acceptable.
REQ-023 An acceptable segment with RST set SHALL pulse conn_refused and go to CLOSED; RST takes priority over SYN.
REQ-024 An acceptable segment with SYN set and RST clear SHALL capture irs=seg_rx_seq and go to ACK_SEND.
REQ-025 A segment with ACK set, ack!=ISS+1 and RST clear SHALL go to RST_SEND with seq=seg_rx_ack, flags=RST.
REQ-026 After RST_SEND, the block SHALL return to SYN_SENT without resetting the RTO count.
REQ-027 A segment with ACK clear SHALL be ignored, including RST-only and SYN-only (no simultaneous open).
REQ-028 ACK_SEND SHALL drive flags=ACK, seq=ISS+1, ack=irs+1, wrapping mod 2^32 (32'hFFFF_FFFF+1=0), and go to ESTABLISHED on handshake.
REQ-029 ESTABLISHED SHALL drive established=1; an rx RST with seq==irs+1 SHALL pulse conn_reset and go to CLOSED; all other segments SHALL be ignored.
REQ-030 Event priority in SYN_SENT: when a segment and RTO expiry coincide, the segment SHALL win and the RTO SHALL not fire.
REQ-031 retry_cnt SHALL clear on entry to CLOSED and on the CLOSED->SYN_SEND transition.

Reset
REQ-032 rst_n low SHALL force, asynchronously: state=CLOSED, seg_tx_valid=0, tx fields=0, established=0, all pulses=0, irs=0, retry_cnt=0, RTO count=0.
REQ-033 Reset mid-handshake SHALL drop seg_tx_valid immediately, and no pulse SHALL be emitted.

Structure
REQ-034 The enum e_init_states and the flag-bit index localparams SHALL be added to global_package alongside e_events and e_states.
REQ-035 The RTO counter SHALL be a sub-module tcp_rto_timer (inputs start and clear; output expired).

Verification
REQ-036 Nominal open: open_req; SYN taken; rx {SYN|ACK, seq=32'h5000, ack=32'h1001} -> tx ACK seq=32'h1001 ack=32'h5001, then established=1.
REQ-037 Refusal: in SYN_SENT, rx {RST|ACK, ack=32'h1001} -> conn_refused pulse, state=CLOSED, no tx.
REQ-038 Timeout, with RTO_CYCLES=8 and MAX_RETRIES=2: no response -> 3 SYNs total, then conn_timeout at 8 cycles after the last SYN handshake.
REQ-039 Bad ACK: rx {ACK, ack=32'h2222} -> tx RST seq=32'h2222, return to SYN_SENT; a later valid SYN|ACK still establishes.
REQ-040 Wrap and backpressure: rx seq=32'hFFFF_FFFF with seg_tx_ready held low for 5 cycles -> fields stable, then ack=32'h0000_0000.
REQ-041 Reset during ACK_SEND -> seg_tx_valid=0 and state=CLOSED before the next clock edge.
